// File: rtl/adc_fifo_writer.sv
// adc_fifo_writer: producer end of the ADC sample FIFO.
// Captures 12-bit ADC samples after arm/trigger, packs them into 24-bit
// words (two full-resolution or three 8-bit samples per word) and drives
// the FIFO write port, plus sticky error status, write counters and
// streaming segment markers.
// Optional build macro: ADC_FIFO_WRITER_DOWNSAMPLE_EN adds the 16-bit
// 'downsample' input (keep one sample every N clocks).
module adc_fifo_writer #(
  parameter int pSAMPLE_CNT_W = 32
) (
  input  logic                     clk_adc,
  input  logic                     reset_n,
  input  logic [11:0]              adc_data,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [pSAMPLE_CNT_W-1:0] max_samples,
  input  logic                     low_res,
  input  logic                     low_res_lsb,
  input  logic [31:0]              stream_segment_threshold,
  input  logic                     clear_fifo_errors,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [23:0]              fifo_wr_data,
  output logic [7:0]               fifo_error_stat,
  output logic                     capture_done,
  output logic                     segment_done,
  output logic                     busy,
  output logic [31:0]              fifo_write_count,
  output logic [31:0]              fifo_write_count_error_freeze
`ifdef ADC_FIFO_WRITER_DOWNSAMPLE_EN
  ,
  input  logic [15:0]              downsample
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0]               state;
  logic                     arm_q;
  logic                     trigger_q;
  logic                     arm_rise;
  logic                     trigger_rise;
  logic                     low_res_q;
  logic                     low_res_lsb_q;
  logic [1:0]               slot;
  logic [1:0]               slot_next;
  logic [23:0]              acc;
  logic [23:0]              acc_next;
  logic                     word_full;
  logic [7:0]               sample8;
  logic [pSAMPLE_CNT_W-1:0] sample_cnt;
  logic [pSAMPLE_CNT_W-1:0] sample_cnt_next;
  logic                     cap_reached;
  logic                     streaming;
  logic [31:0]              seg_cnt;
  logic [31:0]              seg_next;
  logic                     seg_hit;
  logic                     wr_pending;
  logic                     wr_ok;
  logic                     wr_drop;
  logic [7:0]               new_err;
  logic                     keep;

  assign arm_rise        = arm & ~arm_q;
  assign trigger_rise    = trigger & ~trigger_q;
  assign busy            = (state != ST_IDLE);
  assign fifo_wr_en      = wr_pending & ~fifo_full;
  assign wr_ok           = wr_pending & ~fifo_full;
  assign wr_drop         = wr_pending & fifo_full;
  assign streaming       = (max_samples == '0);
  assign sample_cnt_next = sample_cnt + 1'b1;
  assign cap_reached     = !streaming && (sample_cnt_next == max_samples);
  assign seg_next        = seg_cnt + 32'd1;
  assign seg_hit         = streaming && (stream_segment_threshold != 32'd0) &&
                           (seg_next == stream_segment_threshold);
  assign new_err         = {5'b0, arm_rise & busy,
                            trigger_rise & (state != ST_ARMED), wr_drop};

`ifdef ADC_FIFO_WRITER_DOWNSAMPLE_EN
  logic [15:0] ds_cnt;
  logic [15:0] ds_next;

  // Downsample phase: keep the sample whenever the phase counter is zero
  always_comb begin
    ds_next = 16'd0;
    if (downsample > 16'd1 && ds_cnt != downsample - 16'd1) begin
      ds_next = ds_cnt + 16'd1;
    end
  end

  assign keep = (ds_cnt == 16'd0);

  // Phase counter restarts on trigger so the first post-trigger sample is kept
  always_ff @(posedge clk_adc) begin
    if (!reset_n) begin
      ds_cnt <= 16'd0;
    end else if (state == ST_ARMED) begin
      ds_cnt <= 16'd0;
    end else if (state == ST_CAPTURE) begin
      ds_cnt <= ds_next;
    end
  end
`else
  assign keep = 1'b1;
`endif

  // Place the incoming sample into the next free slot of the word being built
  always_comb begin
    sample8   = low_res_lsb_q ? adc_data[7:0] : adc_data[11:4];
    acc_next  = acc;
    slot_next = slot;
    word_full = 1'b0;
    if (low_res_q) begin
      case (slot)
        2'd0: begin
          acc_next  = {sample8, 16'h0000};
          slot_next = 2'd1;
        end
        2'd1: begin
          acc_next  = {acc[23:16], sample8, 8'h00};
          slot_next = 2'd2;
        end
        default: begin
          acc_next  = {acc[23:8], sample8};
          slot_next = 2'd0;
          word_full = 1'b1;
        end
      endcase
    end else if (slot == 2'd0) begin
      acc_next  = {adc_data, 12'h000};
      slot_next = 2'd1;
    end else begin
      acc_next  = {acc[23:12], adc_data};
      slot_next = 2'd0;
      word_full = 1'b1;
    end
  end

  // Registered copies of arm/trigger for rising-edge detection
  always_ff @(posedge clk_adc) begin
    if (!reset_n) begin
      arm_q     <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      arm_q     <= arm;
      trigger_q <= trigger;
    end
  end

  // Capture FSM: packing, write strobes, done and segment pulses
  always_ff @(posedge clk_adc) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      low_res_q     <= 1'b0;
      low_res_lsb_q <= 1'b0;
      slot          <= 2'd0;
      acc           <= 24'h0;
      sample_cnt    <= '0;
      seg_cnt       <= 32'd0;
      wr_pending    <= 1'b0;
      fifo_wr_data  <= 24'h0;
      capture_done  <= 1'b0;
      segment_done  <= 1'b0;
    end else begin
      wr_pending   <= 1'b0;
      capture_done <= 1'b0;
      segment_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm_rise) begin
            state      <= ST_ARMED;
            slot       <= 2'd0;
            acc        <= 24'h0;
            sample_cnt <= '0;
            seg_cnt    <= 32'd0;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state <= ST_IDLE;
          end else if (trigger_rise) begin
            state         <= ST_CAPTURE;
            low_res_q     <= low_res;
            low_res_lsb_q <= low_res_lsb;
            slot          <= 2'd0;
            sample_cnt    <= '0;
            seg_cnt       <= 32'd0;
          end
        end
        ST_CAPTURE: begin
          if (!arm) begin
            state <= ST_FLUSH;
            if (slot != 2'd0) begin
              wr_pending   <= 1'b1;
              fifo_wr_data <= acc;
            end
          end else if (keep) begin
            acc        <= acc_next;
            slot       <= slot_next;
            sample_cnt <= sample_cnt_next;
            if (word_full || (cap_reached && slot_next != 2'd0)) begin
              wr_pending   <= 1'b1;
              fifo_wr_data <= acc_next;
            end
            if (cap_reached) begin
              state <= ST_FLUSH;
            end
            if (streaming && stream_segment_threshold != 32'd0) begin
              if (seg_hit) begin
                seg_cnt      <= 32'd0;
                segment_done <= 1'b1;
              end else begin
                seg_cnt <= seg_next;
              end
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          slot         <= 2'd0;
          capture_done <= 1'b1;
        end
      endcase
    end
  end

  // Write counter: cleared by a fresh arm, bumped after each accepted write
  always_ff @(posedge clk_adc) begin
    if (!reset_n) begin
      fifo_write_count <= 32'd0;
    end else if (state == ST_IDLE && arm_rise) begin
      fifo_write_count <= 32'd0;
    end else if (wr_ok) begin
      fifo_write_count <= fifo_write_count + 32'd1;
    end
  end

  // Sticky errors and freeze snapshot; a new error beats a same-cycle clear
  always_ff @(posedge clk_adc) begin
    if (!reset_n) begin
      fifo_error_stat               <= 8'h00;
      fifo_write_count_error_freeze <= 32'd0;
    end else begin
      if (clear_fifo_errors) begin
        fifo_error_stat <= new_err;
      end else begin
        fifo_error_stat <= fifo_error_stat | new_err;
      end
      if (new_err != 8'h00 && (fifo_error_stat == 8'h00 || clear_fifo_errors)) begin
        fifo_write_count_error_freeze <= fifo_write_count;
      end else if (clear_fifo_errors) begin
        fifo_write_count_error_freeze <= 32'd0;
      end
    end
  end

endmodule

// File: doc/adc_fifo_writer.md
# adc_fifo_writer

Producer end of the ADC sample FIFO: captures 12-bit ADC samples after arm/trigger, packs them into 24-bit FIFO words (full-resolution or 8-bit low-resolution packing), and drives the FIFO write port. Runs in the ADC clock domain. Supplies the sticky error status, write counters and streaming segment markers that the USB-side FIFO register reader reports.

## Interface
Parameters:
- pSAMPLE_CNT_W, 32, width of sample-count limit and counters.

Ports:
- clk_adc  in  1  ADC sample clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- adc_data  in  12  ADC sample, valid every clk_adc.
- arm  in  1  level; rising edge arms capture from IDLE.
- trigger  in  1  level; rising edge starts capture when ARMED.
- max_samples  in  pSAMPLE_CNT_W  samples per capture; 0 = streaming (until arm falls).
- low_res  in  1  1 = 8-bit packing.
- low_res_lsb  in  1  in low_res, take adc_data[7:0] instead of adc_data[11:4].
- stream_segment_threshold  in  32  samples per streaming segment.
- clear_fifo_errors  in  1  one-cycle pulse; clears error_stat and freeze.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_wr_en  out  1  write strobe.
- fifo_wr_data  out  24  packed word.
- fifo_error_stat  out  8  sticky errors.
- capture_done  out  1  one-cycle pulse when capture completes.
- segment_done  out  1  one-cycle pulse per streaming segment.
- busy  out  1  high in ARMED, CAPTURE, FLUSH.
- fifo_write_count  out  32  words written since arm.
- fifo_write_count_error_freeze  out  32  fifo_write_count at first error.

## Operation
- FSM: IDLE -> ARMED on arm rise; ARMED -> CAPTURE on trigger rise; ARMED -> IDLE on arm low; CAPTURE -> FLUSH when sample count reaches max_samples (max_samples≠0) or arm low; FLUSH -> IDLE after the partial word (if any) is written; capture_done pulses on FLUSH exit.
- Arm rise in IDLE clears fifo_write_count, sample counter, packing slot.
- Packing, full-res: 2 samples/word; first sample in [23:12], second in [11:0].
- Packing, low-res: 3 samples/word; first in [23:16], then [15:8], then [7:0].
- Partial word at end of capture: unused slots zero; written once in FLUSH; no write if slot is empty.
- low_res/low_res_lsb sampled on trigger rise; ignored during CAPTURE.
- Write with fifo_full high: word dropped, fifo_wr_en stays low, error_stat[0] set, capture continues.
- error_stat[1]: trigger rise outside ARMED. error_stat[2]: arm rise while busy (ignored). Bits [7:3] = 0.
- Freeze register loads fifo_write_count on the cycle any error bit first goes 0->1 from all-zero; holds until clear_fifo_errors.
- Streaming: segment counter counts samples; segment_done pulses when it reaches stream_segment_threshold, then restarts at 0. Threshold 0 disables segment_done.
- Counters wrap at 2^32 without error.

## Timing
- Reset values: fifo_wr_en 0, fifo_wr_data 0, fifo_error_stat 0, capture_done 0, segment_done 0, busy 0, both counts 0, state IDLE.
- Trigger rise sampled at cycle T; first captured sample is adc_data at T+1.
- Word completed by sample at cycle N is written at N+1 (fifo_wr_en high one cycle, data stable that cycle).
- fifo_full is evaluated in the write cycle itself.
- fifo_write_count increments in the cycle after a successful write.
- clear_fifo_errors and a new error in the same cycle: new error wins (bit set, freeze loaded).
- reset_n low mid-capture: all state cleared next edge; no flush write.

## Configuration
- ADC_FIFO_WRITER_DOWNSAMPLE_EN defined: adds input downsample (16 bits, after the existing ports); 0 or 1 keeps every sample, N keeps one sample per N clocks starting with the first post-trigger sample; max_samples and segments count kept samples.
- Undefined: port absent; every sample kept.

## Test plan
- Full-res, max_samples=4, ramp 0x001,0x002,...: two writes 0x001002, 0x003004; capture_done one cycle after second write; count=2.
- Low-res, low_res_lsb=0, max_samples=4, adc 0xAB0,0xCD0,0xEF0,0x120: writes 0xABCDEF then flush 0x120000.
- fifo_full high on second word of a 6-sample full-res capture: words 1 and 3 written, error_stat=0x01, freeze=1; clear_fifo_errors -> error_stat=0, freeze=0.
- Streaming (max_samples=0), threshold=3, full-res: segment_done at samples 3,6,9; arm low after 7 samples -> flush word with sample 7 in [23:12], zeros below.
- Trigger in IDLE -> error_stat=0x02, no writes; reset_n low mid-capture -> all outputs reset, no further writes.
- With ADC_FIFO_WRITER_DOWNSAMPLE_EN, downsample=3, max_samples=2, ramp from 0x000: single write 0x000003.
